// File: rtl/fp_to_pixel.sv
// Converts an IEEE-754 single-precision gray value to an 8-bit pixel through a
// 3-stage pipeline: field split/classify, integer+round extraction, clamp.
module fp_to_pixel #(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [31:0]          fp_in,
  output logic                 valid_out,
  output logic [7:0]           pixel_out,
  output logic                 sat_out,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [22:0] s1_mant;
  logic        s1_zero;
  logic        s1_nan;
  logic        s1_inf;

  logic        s2_valid;
  logic        s2_sign;
  logic        s2_zero;
  logic        s2_nan;
  logic        s2_inf;
  logic        s2_ovf;
  logic [8:0]  s2_res;

  logic [23:0] sig;
  logic [8:0]  shifted;
  logic [8:0]  res_d;
  logic        ovf_d;
  logic [7:0]  pix_d;
  logic        sat_d;

  // Stage 1: split fields and classify. Data registers load every cycle;
  // only the valid bit qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_zero  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      s1_sign  <= fp_in[31];
      s1_exp   <= fp_in[30:23];
      s1_mant  <= fp_in[22:0];
      s1_zero  <= (fp_in[30:23] == 8'd0);
      s1_nan   <= (fp_in[30:23] == 8'hFF) && (fp_in[22:0] != 23'd0);
      s1_inf   <= (fp_in[30:23] == 8'hFF) && (fp_in[22:0] == 23'd0);
    end
  end

  // Shifting by (149 - exp) leaves the integer part in [8:1] and the first
  // fractional bit in [0]; this also covers exp=126 (int 0, round 1).
  assign sig = {1'b1, s1_mant};

  always_comb begin
    shifted = '0;
    res_d   = '0;
    ovf_d   = 1'b0;
    if (s1_exp >= 8'd135) begin
      ovf_d = 1'b1;
    end else if (s1_exp >= 8'd126) begin
      shifted = 9'(sig >> (8'd149 - s1_exp));
      res_d   = {1'b0, shifted[8:1]} + {8'd0, shifted[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_res   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_ovf   <= ovf_d;
      s2_res   <= res_d;
    end
  end

  // Stage 3 clamp; zero/denormal wins over sign so -0 is not a saturation.
  always_comb begin
    pix_d = s2_res[7:0];
    sat_d = 1'b0;
    if (s2_zero) begin
      pix_d = 8'd0;
    end else if (s2_nan) begin
      pix_d = 8'd0;
      sat_d = 1'b1;
    end else if (s2_inf) begin
      pix_d = s2_sign ? 8'd0 : 8'd255;
      sat_d = 1'b1;
    end else if (s2_sign) begin
      pix_d = 8'd0;
      sat_d = 1'b1;
    end else if (s2_ovf || s2_res[8]) begin
      pix_d = 8'd255;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      pixel_out <= '0;
      sat_out   <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      valid_out <= s2_valid;
      if (s2_valid) begin
        pixel_out <= pix_d;
        sat_out   <= sat_d;
        if (sat_d && (sat_cnt != '1)) sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_pixel.sv
// Directed bench for fp_to_pixel: vector table for conversion/latency, plus
// throughput, counter saturation and mid-stream reset sequences.
module tb_fp_to_pixel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] fp_in = '0;
  logic        valid_out;
  logic [7:0]  pixel_out;
  logic        sat_out;
  logic [15:0] sat_cnt;
  logic        valid_out4;
  logic [7:0]  pixel_out4;
  logic        sat_out4;
  logic [3:0]  sat_cnt4;

  int errors = 0;
  int checks = 0;

  fp_to_pixel #(.SAT_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .fp_in(fp_in),
    .valid_out(valid_out), .pixel_out(pixel_out), .sat_out(sat_out), .sat_cnt(sat_cnt)
  );

  fp_to_pixel #(.SAT_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .fp_in(fp_in),
    .valid_out(valid_out4), .pixel_out(pixel_out4), .sat_out(sat_out4), .sat_cnt(sat_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fp;
    logic [7:0]  pix;
    logic        sat;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // One sample, then idle with a NaN on fp_in to show invalid data is ignored.
  task automatic run_vec(input logic [31:0] fp, input logic [7:0] pix, input logic sat, input string name);
    @(negedge clk);
    fp_in = fp;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    fp_in = 32'h7FC00000;
    @(negedge clk);
    chk({name, " early valid"}, {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    chk({name, " valid"}, {31'd0, valid_out}, 32'd1);
    chk({name, " pixel"}, {24'd0, pixel_out}, {24'd0, pix});
    chk({name, " sat"}, {31'd0, sat_out}, {31'd0, sat});
    @(negedge clk);
    chk({name, " single pulse"}, {31'd0, valid_out}, 32'd0);
    chk({name, " hold pixel"}, {24'd0, pixel_out}, {24'd0, pix});
    chk({name, " hold sat"}, {31'd0, sat_out}, {31'd0, sat});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] int_to_fp(input int k);
    int p;
    logic [31:0] m;
    logic [7:0] e;
    if (k == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 8; i++) if (k[i]) p = i;
    m = 32'(k) << (23 - p);
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  initial begin
    int exp_sat;

    vecs[0]  = '{32'h437F0000, 8'd255, 1'b0};
    vecs[1]  = '{32'h42F70000, 8'd124, 1'b0};
    vecs[2]  = '{32'h3F000000, 8'd1,   1'b0};
    vecs[3]  = '{32'h3EFFFFFF, 8'd0,   1'b0};
    vecs[4]  = '{32'h437F8000, 8'd255, 1'b1};
    vecs[5]  = '{32'h7F800000, 8'd255, 1'b1};
    vecs[6]  = '{32'hBF800000, 8'd0,   1'b1};
    vecs[7]  = '{32'h7FC00000, 8'd0,   1'b1};
    vecs[8]  = '{32'h80000000, 8'd0,   1'b0};
    vecs[9]  = '{32'h3F800000, 8'd1,   1'b0};
    vecs[10] = '{32'h3FC00000, 8'd2,   1'b0};
    vecs[11] = '{32'h40200000, 8'd3,   1'b0};
    vecs[12] = '{32'h00000001, 8'd0,   1'b0};
    vecs[13] = '{32'hFF800000, 8'd0,   1'b1};
    vecs[14] = '{32'h437F7FFF, 8'd255, 1'b0};
    vecs[15] = '{32'h4B000000, 8'd255, 1'b1};
    vecs[16] = '{32'h43000000, 8'd128, 1'b0};
    vecs[17] = '{32'h3F7FFFFF, 8'd1,   1'b0};
    vecs[18] = '{32'hC2F70000, 8'd0,   1'b1};
    vecs[19] = '{32'h3E800000, 8'd0,   1'b0};
    vecs[20] = '{32'h43060000, 8'd134, 1'b0};
    vecs[21] = '{32'h7F800001, 8'd0,   1'b1};
    vecs[22] = '{32'h437F4000, 8'd255, 1'b0};
    vecs[23] = '{32'h43800000, 8'd255, 1'b1};
    vecs[24] = '{32'h40A00000, 8'd5,   1'b0};

    #2 rst = 1'b1;
    #1;
    chk("reset valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset pixel_out", {24'd0, pixel_out}, 32'd0);
    chk("reset sat_out", {31'd0, sat_out}, 32'd0);
    chk("reset sat_cnt", {16'd0, sat_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    exp_sat = 0;
    for (int i = 0; i < 25; i++) begin
      run_vec(vecs[i].fp, vecs[i].pix, vecs[i].sat, $sformatf("vec%0d", i));
      if (vecs[i].sat) exp_sat++;
    end
    chk("table sat_cnt", {16'd0, sat_cnt}, 32'(exp_sat));

    // Throughput: float(k) back to back, then one idle cycle.
    pulse_reset();
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 258) begin
        chk($sformatf("stream valid %0d", c - 3), {31'd0, valid_out}, 32'd1);
        chk($sformatf("stream pixel %0d", c - 3), {24'd0, pixel_out}, 32'(c - 3));
      end else if (c == 259) begin
        chk("stream idle valid", {31'd0, valid_out}, 32'd0);
        chk("stream idle hold", {24'd0, pixel_out}, 32'd255);
      end
      if (c < 256) begin
        valid_in = 1'b1;
        fp_in = int_to_fp(c);
      end else begin
        valid_in = 1'b0;
      end
    end
    chk("stream sat_cnt", {16'd0, sat_cnt}, 32'd0);

    // Counter saturation on the 4-bit instance.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      fp_in = 32'h7FC00000;
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("cnt4 sticks", {28'd0, sat_cnt4}, 32'd15);
    chk("cnt16 counts", {16'd0, sat_cnt}, 32'd20);

    // Mid-stream reset: leave nonzero held outputs, launch 3, reset before any emerges.
    run_vec(32'h7F800000, 8'd255, 1'b1, "pre-reset inf");
    @(negedge clk);
    valid_in = 1'b1;
    fp_in = 32'h43480000;
    @(negedge clk);
    fp_in = 32'h43490000;
    @(negedge clk);
    fp_in = 32'h434A0000;
    #2 rst = 1'b1;
    #1;
    chk("async rst valid_out", {31'd0, valid_out}, 32'd0);
    chk("async rst pixel_out", {24'd0, pixel_out}, 32'd0);
    chk("async rst sat_out", {31'd0, sat_out}, 32'd0);
    chk("async rst sat_cnt", {16'd0, sat_cnt}, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("flushed valid %0d", i), {31'd0, valid_out}, 32'd0);
    end
    run_vec(32'h42C80000, 8'd100, 1'b0, "post-reset");
    chk("post-reset sat_cnt", {16'd0, sat_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
